// File: rtl/decode_scan_pkg.sv
// rtl/decode_scan_pkg.sv - shared types, sizes and channel search helper for the decode scan controller
// Contents: state_t (IDLE/DWELL/DONE), NUM_CH, SEL_W, first_ch().
package decode_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Lowest enabled channel at index >= from. MSB of the result is the
    // found flag, the low SEL_W bits the channel index. Scanning downward
    // lets the last hit (the lowest index) win.
    function automatic logic [SEL_W:0] first_ch(input logic [NUM_CH-1:0] m, input int from);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_scan_ctrl_if.sv
// rtl/decode_scan_ctrl_if.sv - control/status bundle between a scan requester and the decode scan controller
// master: drives start, stop, cont, mask, dwell; receives sel, en, ch_start, busy, done.
// slave : the controller side (directions reversed).
interface decode_scan_ctrl_if
    import decode_scan_pkg::*;
#(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               cont;
    logic [NUM_CH-1:0]  mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic               en;
    logic               ch_start;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, cont, mask, dwell,
        input  sel, en, ch_start, busy, done
    );

    modport slave (
        input  start, stop, cont, mask, dwell,
        output sel, en, ch_start, busy, done
    );
endinterface

// File: rtl/decode_scan_dwell_cnt.sv
// rtl/decode_scan_dwell_cnt.sv - per-channel dwell down-counter with expiry flag
// Ports: clk, rst (async, active-high), load_i/load_val_i (reload), dec_i (count down),
//        expired_o (count has reached zero: current cycle is the last of the dwell).
module decode_scan_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               expired_o
);
    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/decode_scan_ctrl.sv
// rtl/decode_scan_ctrl.sv - channel sweep controller driving a 3-to-8 decoder (sel/en)
// Ports: clk, rst (async, active-high), bus (decode_scan_ctrl_if.slave).
// Macro SCAN_SKIP_MASK_EN: when defined, only channels with their mask bit set are visited;
// otherwise mask is ignored and channels 0..7 are all visited.
module decode_scan_ctrl
    import decode_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_scan_ctrl_if.slave    bus
);
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_q, en_d;
    logic               ch_start_q, ch_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    // Holds effective dwell minus one, i.e. the counter reload value.
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               cnt_load, cnt_dec, cnt_expired;
    logic [DWELL_W-1:0] cnt_load_val;
    logic [NUM_CH-1:0]  in_mask;
    logic [DWELL_W-1:0] start_dwell_m1;
    logic [SEL_W:0]     pick_start, pick_next, pick_first;

`ifdef SCAN_SKIP_MASK_EN
    assign in_mask = bus.mask;
`else
    assign in_mask = '1;
`endif

    // A dwell of zero behaves like one: both reload as zero.
    assign start_dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    assign pick_start = first_ch(in_mask, 0);
    assign pick_next  = first_ch(mask_q, int'(sel_q) + 1);
    assign pick_first = first_ch(mask_q, 0);

    decode_scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .expired_o  (cnt_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            en_q       <= 1'b0;
            ch_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mask_q     <= '0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            ch_start_q <= ch_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mask_q     <= mask_d;
            dwell_q    <= dwell_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = 1'b0;
        ch_start_d   = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        mask_d       = mask_q;
        dwell_d      = dwell_q;
        cnt_load     = 1'b0;
        cnt_load_val = dwell_q;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    mask_d  = in_mask;
                    dwell_d = start_dwell_m1;
                    busy_d  = 1'b1;
                    if (pick_start[SEL_W]) begin
                        state_d      = DWELL;
                        sel_d        = pick_start[SEL_W-1:0];
                        en_d         = 1'b1;
                        ch_start_d   = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = start_dwell_m1;
                    end else begin
                        // Nothing enabled: report an empty sweep.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DWELL: begin
                busy_d = 1'b1;
                en_d   = 1'b1;
                if (cnt_expired) begin
                    if (pick_next[SEL_W]) begin
                        sel_d      = pick_next[SEL_W-1:0];
                        ch_start_d = 1'b1;
                        cnt_load   = 1'b1;
                    end else if (bus.cont && pick_first[SEL_W]) begin
                        sel_d      = pick_first[SEL_W-1:0];
                        ch_start_d = 1'b1;
                        cnt_load   = 1'b1;
                    end else begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (bus.stop) begin
            state_d    = IDLE;
            sel_d      = sel_q;
            en_d       = 1'b0;
            ch_start_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            mask_d     = mask_q;
            dwell_d    = dwell_q;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.en       = en_q;
    assign bus.ch_start = ch_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_decode_scan_ctrl.sv
// tb/tb_decode_scan_ctrl.sv - directed self-checking bench for decode_scan_ctrl
module tb_decode_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_ch[$];
    int   last_sel = 0;

    decode_scan_ctrl_if #(.DWELL_W(8)) bus ();

    decode_scan_ctrl #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] v(input int s, input bit e, input bit cs, input bit b, input bit d);
        return {3'(s), e, cs, b, d};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.sel, bus.en, bus.ch_start, bus.busy, bus.done};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed sel/en/cs/busy/done=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic kick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic all_ch();
        exp_ch = {};
        for (int i = 0; i < 8; i++) exp_ch.push_back(i);
    endtask

    // Walks exp_ch, each channel for the effective dwell; optionally pulses
    // start at cycle busy_start_at, which must be ignored.
    task automatic sweep(input string name, input int dw, input int busy_start_at);
        int eff;
        int n;
        eff = (dw == 0) ? 1 : dw;
        n = 0;
        foreach (exp_ch[k]) begin
            for (int j = 0; j < eff; j++) begin
                check($sformatf("%s ch%0d c%0d", name, exp_ch[k], j), v(exp_ch[k], 1'b1, j == 0, 1'b1, 1'b0));
                if (n == busy_start_at) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                n++;
            end
        end
        last_sel = exp_ch[exp_ch.size() - 1];
    endtask

    task automatic expect_done(input string name, input int s);
        check({name, " done"}, v(s, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();
        check({name, " idle"}, v(s, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cont  = 1'b0;
        bus.mask  = 8'h00;
        bus.dwell = 8'd0;
        tick();
        tick();
        check("reset", v(0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Single sweep; start on the first edge after reset release.
        rst       = 1'b0;
        bus.mask  = 8'hFF;
        bus.dwell = 8'd2;
        bus.cont  = 1'b0;
        kick();
        all_ch();
        sweep("single", 2, -1);
        expect_done("single", 7);

        // Skip pattern; mask/dwell changed mid-sweep must not matter.
        bus.mask  = 8'b1010_0100;
        bus.dwell = 8'd1;
        kick();
        bus.mask  = 8'h01;
        bus.dwell = 8'd5;
`ifdef SCAN_SKIP_MASK_EN
        exp_ch = {2, 5, 7};
`else
        all_ch();
`endif
        sweep("skip", 1, -1);
        expect_done("skip", last_sel);

        // Continuous: two full sweeps, then clear cont during the third.
        bus.mask  = 8'h03;
        bus.dwell = 8'd3;
        bus.cont  = 1'b1;
        kick();
`ifdef SCAN_SKIP_MASK_EN
        exp_ch = {0, 1};
`else
        all_ch();
`endif
        sweep("cont1", 3, -1);
        sweep("cont2", 3, -1);
        bus.cont = 1'b0;
        sweep("cont3", 3, -1);
        expect_done("cont", last_sel);

        // Abort during channel 4.
        bus.mask  = 8'hFF;
        bus.dwell = 8'd2;
        kick();
        exp_ch = {0, 1, 2, 3};
        sweep("abort", 2, -1);
        check("abort ch4", v(4, 1'b1, 1'b1, 1'b1, 1'b0));
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort idle%0d", i), v(4, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
        end

        // stop and start together in IDLE.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("stopstart0", v(4, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        check("stopstart1", v(4, 1'b0, 1'b0, 1'b0, 1'b0));

        // dwell=0 acts as 1; a start while busy is ignored.
        bus.mask  = 8'h81;
        bus.dwell = 8'd0;
        kick();
`ifdef SCAN_SKIP_MASK_EN
        exp_ch = {0, 7};
`else
        all_ch();
`endif
        sweep("dw0", 0, 1);
        expect_done("dw0", 7);

        // mask=0.
        bus.mask  = 8'h00;
        bus.dwell = 8'd1;
        kick();
`ifdef SCAN_SKIP_MASK_EN
        expect_done("mask0", 7);
`else
        all_ch();
        sweep("mask0", 1, -1);
        expect_done("mask0", 7);
`endif

        // Asynchronous reset mid-dwell, then an immediate restart.
        bus.mask  = 8'hFF;
        bus.dwell = 8'd1;
        kick();
        tick();
        tick();
        tick();
        check("pre_rst ch3", v(3, 1'b1, 1'b1, 1'b1, 1'b0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", v(0, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        rst       = 1'b0;
        bus.dwell = 8'd2;
        kick();
        exp_ch = {0};
        sweep("post_rst", 2, -1);
        check("post_rst ch1", v(1, 1'b1, 1'b1, 1'b1, 1'b0));
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("post_rst stop", v(1, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_scan_ctrl.md
DECODE_SCAN_CTRL -- requirements
Module: decode_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8: width of the per-channel dwell count.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1: one-cycle request to begin a sweep.
REQ-005 SHALL have port stop  input  1: abort request, sampled on every clock edge.
REQ-006 SHALL have port cont  input  1: 1 = wrap and sweep continuously; 0 = single sweep.
REQ-007 SHALL have port mask  input  8: channel-enable bits, bit i = channel i.
REQ-008 SHALL have port dwell  input  DWELL_W: cycles each channel stays selected; sampled at start.
REQ-009 SHALL have port sel  output  3: channel index driven to the downstream 3-to-8 decoder.
REQ-010 SHALL have port en  output  1: decoder enable; high only while a channel is being dwelt on.
REQ-011 SHALL have port ch_start  output  1: one-cycle pulse in the first cycle of each channel's dwell.
REQ-012 SHALL have port busy  output  1: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port done  output  1: one-cycle pulse when a single sweep completes normally.

Function
REQ-014 SHALL implement FSM states IDLE, DWELL, DONE; all outputs registered.
REQ-015 IDLE + start=1 + stop=0 SHALL, at that edge, latch dwell, select the lowest enabled channel, and enter DWELL; sel/en/ch_start/busy valid the following cycle.
REQ-016 An effective dwell of 0 SHALL be treated as 1.
REQ-017 In DWELL, en SHALL be 1 for exactly the effective dwell cycles per channel, with sel constant.
REQ-018 At dwell expiry, the FSM SHALL advance sel to the next higher enabled channel with no en gap, and pulse ch_start.
REQ-019 After the highest enabled channel: cont=1 SHALL wrap to the lowest enabled channel; cont=0 SHALL enter DONE.
REQ-020 DONE SHALL last one cycle with done=1, en=0, busy=1, then return to IDLE.
REQ-021 cont SHALL be sampled at each sweep end, so clearing it mid-sweep ends after the current sweep.
REQ-022 stop=1 in any state SHALL force IDLE at that edge, en=0, with no done pulse; stop wins over simultaneous start.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 sel SHALL hold its last value in IDLE and DONE.
REQ-025 mask and dwell changes during a sweep SHALL NOT affect it (both latched at start).
REQ-026 mask=0 at start: the FSM SHALL go directly to DONE, so done pulses one cycle after start with en never asserted.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, sel=0, en=0, ch_start=0, busy=0, done=0, and clear the dwell counter and latched mask/dwell, including mid-sweep.
REQ-028 The first start SHALL be honoured on the first clock edge after rst deasserts.

Configuration
REQ-029 With macro SCAN_SKIP_MASK_EN defined, the FSM SHALL visit only channels whose mask bit is set.
REQ-030 Without SCAN_SKIP_MASK_EN, mask SHALL be ignored, all channels 0..7 SHALL be visited in order, and REQ-026 SHALL not apply.

Structure
REQ-031 Package decode_scan_pkg SHALL hold the state enum, NUM_CH=8 and SEL_W=3.
REQ-032 The dwell down-counter SHALL be a sub-module decode_scan_dwell_cnt (load, decrement, expiry flag).

Verification
REQ-033 Single sweep: mask=8'hFF, dwell=2, cont=0, start -> sel 0..7, each en for 2 cycles, 8 ch_start pulses, done 17 cycles after start.
REQ-034 Skip: macro on, mask=8'b1010_0100, dwell=1 -> sel 2,5,7 one cycle each, then done; macro off -> all 8 channels visited.
REQ-035 Continuous: mask=8'h03, dwell=3, cont=1 -> sel 0,0,0,1,1,1 repeating; clear cont mid-sweep -> done after channel 1.
REQ-036 Abort: stop asserted during channel 4 -> next cycle en=0, busy=0, no done; stop+start together in IDLE -> stays IDLE.
REQ-037 Edge cases: dwell=0 behaves as dwell=1; mask=0 with macro on -> done one cycle after start and en never high; start while busy ignored.
REQ-038 Reset: rst pulsed asynchronously mid-DWELL -> all outputs 0 immediately; start on the first edge after release works.
